// File: rtl/number_checker.sv
// Grades a player's answer against a generator-supplied target and keeps a saturating score.
// Optional answer timeout in WAIT is built only when ANSWER_TIMEOUT_EN is defined.
module number_checker #(
  parameter int WIDTH       = 4,
  parameter int SCORE_W     = 8,
  parameter int RESULT_CYC  = 50,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               gen_enable,
  input  logic [0:WIDTH-1]   gen_result,
  input  logic [0:WIDTH-1]   answer,
  input  logic               submit,
  output logic [0:WIDTH-1]   target,
  output logic               correct,
  output logic               wrong,
  output logic               timeout,
  output logic [SCORE_W-1:0] score,
  output logic               busy
);

  localparam int CMAX = (RESULT_CYC > TIMEOUT_CYC) ? RESULT_CYC : TIMEOUT_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_WAIT, S_SHOW} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [0:WIDTH-1]   target_nxt;
  logic               correct_nxt, wrong_nxt;
  logic [SCORE_W-1:0] score_nxt;
`ifdef ANSWER_TIMEOUT_EN
  logic               timeout_q, timeout_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    target_nxt  = target;
    correct_nxt = correct;
    wrong_nxt   = wrong;
    score_nxt   = score;
`ifdef ANSWER_TIMEOUT_EN
    timeout_nxt = timeout_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          score_nxt = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: begin
        target_nxt = gen_result;
        cnt_nxt    = '0;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        // submit has priority over an expiring timer on the same cycle
        if (submit) begin
          if (answer == target) begin
            correct_nxt = 1'b1;
            if (score != '1) score_nxt = score + 1'b1;
          end else begin
            wrong_nxt = 1'b1;
          end
          cnt_nxt   = '0;
          state_nxt = S_SHOW;
        end
`ifdef ANSWER_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          wrong_nxt   = 1'b1;
          timeout_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = S_SHOW;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      S_SHOW: begin
        if (cnt == CW'(RESULT_CYC - 1)) begin
          correct_nxt = 1'b0;
          wrong_nxt   = 1'b0;
`ifdef ANSWER_TIMEOUT_EN
          timeout_nxt = 1'b0;
`endif
          cnt_nxt     = '0;
          state_nxt   = S_FETCH;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // gen_enable and busy are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      target     <= '0;
      correct    <= 1'b0;
      wrong      <= 1'b0;
      score      <= '0;
      gen_enable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      target     <= target_nxt;
      correct    <= correct_nxt;
      wrong      <= wrong_nxt;
      score      <= score_nxt;
      gen_enable <= (state_nxt == S_FETCH);
      busy       <= (state_nxt != S_IDLE);
    end
  end

`ifdef ANSWER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= timeout_nxt;
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_number_checker.sv
// Randomised bench for number_checker: a round-level model tracks target and score.
module tb_number_checker;

  localparam int WIDTH       = 4;
  localparam int SCORE_W     = 2;
  localparam int RESULT_CYC  = 5;
  localparam int TIMEOUT_CYC = 10;
  localparam int SCORE_MAX   = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               submit = 1'b0;
  logic [0:WIDTH-1]   gen_result = '0;
  logic [0:WIDTH-1]   answer = '0;
  logic               gen_enable, correct, wrong, timeout, busy;
  logic [0:WIDTH-1]   target;
  logic [SCORE_W-1:0] score;

  int vecs = 0;
  int errs = 0;
  int exp_score = 0;
  logic [0:WIDTH-1] exp_target = '0;

  number_checker #(
    .WIDTH(WIDTH), .SCORE_W(SCORE_W), .RESULT_CYC(RESULT_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .gen_enable(gen_enable), .gen_result(gen_result),
    .answer(answer), .submit(submit), .target(target), .correct(correct), .wrong(wrong),
    .timeout(timeout), .score(score), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // State just entered FETCH: expect the generator request, then latch a new target.
  task automatic fetch_new(input logic [0:WIDTH-1] v);
    vecs++;
    if (gen_enable !== 1'b1) begin errs++; $display("FAIL fetch_gen_enable got=%b want=1", gen_enable); end
    gen_result = ~v;
    tick;
    vecs++;
    if (gen_enable !== 1'b0) begin errs++; $display("FAIL fetch_gen_enable_one_cycle got=%b want=0", gen_enable); end
    gen_result = v;
    tick;
    gen_result = ~v;
    exp_target = v;
    vecs++;
    if (target !== exp_target) begin errs++; $display("FAIL fetch_target got=%b want=%b", target, exp_target); end
  endtask

  // Flags are already high; count their length, poke submit during SHOW, then refetch.
  task automatic finish_show(input int first_n, input logic [0:WIDTH-1] next_v);
    int n;
    n = first_n;
    while ((correct | wrong) && n < RESULT_CYC + 5) begin
      if (n == 2) begin answer = exp_target; submit = 1'b1; end
      tick;
      submit = 1'b0;
      if (correct | wrong) n++;
    end
    vecs++;
    if (n !== RESULT_CYC) begin errs++; $display("FAIL show_length got=%0d want=%0d", n, RESULT_CYC); end
    vecs++;
    if (score !== SCORE_W'(exp_score)) begin errs++; $display("FAIL show_score got=%0d want=%0d", score, exp_score); end
    fetch_new(next_v);
  endtask

  task automatic play_round(input bit match, input bit poke, input logic [0:WIDTH-1] next_v);
    if (poke) begin
      start = 1'b1;
      tick;
      start = 1'b0;
      vecs++;
      if ({gen_enable, busy, correct, wrong} !== 4'b0100) begin
        errs++; $display("FAIL start_in_wait got=%b want=0100", {gen_enable, busy, correct, wrong});
      end
    end
    answer = match ? exp_target : (exp_target ^ WIDTH'($urandom_range(1, (1 << WIDTH) - 1)));
    submit = 1'b1;
    tick;
    submit = 1'b0;
    if (match) exp_score = (exp_score + 1 > SCORE_MAX) ? SCORE_MAX : exp_score + 1;
    vecs++;
    if ({correct, wrong, timeout} !== {match, !match, 1'b0}) begin
      errs++; $display("FAIL grade_flags got=%b want=%b", {correct, wrong, timeout}, {match, !match, 1'b0});
    end
    vecs++;
    if (score !== SCORE_W'(exp_score)) begin errs++; $display("FAIL grade_score got=%0d want=%0d", score, exp_score); end
    finish_show(1, next_v);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    submit = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    submit = 1'b0;
    vecs++;
    if ({gen_enable, target, correct, wrong, timeout, score, busy} !== '0) begin
      errs++; $display("FAIL reset_outputs got=%b want=0", {gen_enable, target, correct, wrong, timeout, score, busy});
    end
    submit = 1'b1;
    tick;
    submit = 1'b0;
    tick;
    vecs++;
    if ({gen_enable, target, correct, wrong, timeout, score, busy} !== '0) begin
      errs++; $display("FAIL idle_submit got=%b want=0", {gen_enable, target, correct, wrong, timeout, score, busy});
    end
  endtask

  task automatic test_start;
    gen_result = 4'b1010;
    start = 1'b1;
    tick;
    start = 1'b0;
    exp_score = 0;
    vecs++;
    if ({gen_enable, busy} !== 2'b11) begin errs++; $display("FAIL start_fetch got=%b want=11", {gen_enable, busy}); end
    tick;
    vecs++;
    if (gen_enable !== 1'b0) begin errs++; $display("FAIL start_gen_enable_one_cycle got=%b want=0", gen_enable); end
    tick;
    exp_target = 4'b1010;
    gen_result = 4'b0110;
    vecs++;
    if (target !== exp_target) begin errs++; $display("FAIL start_target got=%b want=%b", target, exp_target); end
  endtask

  task automatic test_basic;
    play_round(1'b1, 1'b1, 4'b1010);
    play_round(1'b0, 1'b0, WIDTH'($urandom));
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 4; i++) play_round(1'b1, 1'b0, WIDTH'($urandom));
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) play_round(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), WIDTH'($urandom));
  endtask

`ifdef ANSWER_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    n = 0;
    while (!wrong && n < TIMEOUT_CYC + 5) begin tick; n++; end
    vecs++;
    if (n !== TIMEOUT_CYC) begin errs++; $display("FAIL timeout_delay got=%0d want=%0d", n, TIMEOUT_CYC); end
    vecs++;
    if ({correct, wrong, timeout} !== 3'b011) begin errs++; $display("FAIL timeout_flags got=%b want=011", {correct, wrong, timeout}); end
    finish_show(1, WIDTH'($urandom));
    repeat (TIMEOUT_CYC - 1) tick;
    answer = exp_target;
    submit = 1'b1;
    tick;
    submit = 1'b0;
    exp_score = (exp_score + 1 > SCORE_MAX) ? SCORE_MAX : exp_score + 1;
    vecs++;
    if ({correct, wrong, timeout} !== 3'b100) begin errs++; $display("FAIL expiry_submit got=%b want=100", {correct, wrong, timeout}); end
    finish_show(1, WIDTH'($urandom));
  endtask
`endif

  task automatic test_reset_mid;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vecs++;
    if ({gen_enable, target, correct, wrong, timeout, score, busy} !== '0) begin
      errs++; $display("FAIL midreset_outputs got=%b want=0", {gen_enable, target, correct, wrong, timeout, score, busy});
    end
    answer = '0;
    submit = 1'b1;
    tick;
    submit = 1'b0;
    tick;
    vecs++;
    if ({gen_enable, correct, wrong, busy} !== 4'b0000) begin
      errs++; $display("FAIL midreset_submit got=%b want=0000", {gen_enable, correct, wrong, busy});
    end
  endtask

  initial begin
    test_reset;
    test_start;
    test_basic;
    test_saturation;
    test_random;
`ifdef ANSWER_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
